// File: rtl/fold_mod_reduce_pkg.sv
// Shared types and elaboration-time helpers for the fold_mod_reduce block:
// FSM state encoding, step/table sizing, and the constant function that
// builds the fold table entries T[h] = (h * 2^BITS) mod MODULUS.
package fold_mod_pkg;

  typedef enum logic [2:0] {IDLE, ITER, SUB1, SUB2, DONE} state_t;

  // Working width for table construction; must exceed BITS by at least one.
  localparam int MAX_W = 1024;

  function automatic int num_step(input int bits, input int fold_w);
    return bits / fold_w;
  endfunction

  function automatic int tbl_depth(input int fold_w);
    return 1 << (fold_w + 1);
  endfunction

  // (h << bits) mod modulus by shift-subtract: first reduce h bit by bit,
  // then double-and-reduce once per bit of the 2^bits factor.
  function automatic logic [MAX_W-1:0] fold_tbl_entry(input int h, input int bits,
                                                      input logic [MAX_W-1:0] modulus);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      r = {r[MAX_W-2:0], h[i]};
      if (r >= modulus) r = r - modulus;
    end
    for (int i = 0; i < bits; i++) begin
      r = {r[MAX_W-2:0], 1'b0};
      if (r >= modulus) r = r - modulus;
    end
    return r;
  endfunction

endpackage

// File: rtl/fold_mod_table.sv
// Fold lookup ROM: entry h holds (h * 2^BITS) mod MODULUS, built at
// elaboration. With FOLD_MOD_TABLE_BRAM_EN defined the read is registered
// (one-cycle latency, block-RAM friendly); otherwise it is combinational.
module fold_mod_table
  import fold_mod_pkg::*;
#(
  parameter int               BITS    = 384,
  parameter logic [BITS-1:0]  MODULUS = ~(BITS'(316)),
  parameter int               FOLD_W  = 8
)(
`ifdef FOLD_MOD_TABLE_BRAM_EN
  input  logic              i_clk,
`endif
  input  logic [FOLD_W:0]   addr,
  output logic [BITS-1:0]   data
);

  localparam int DEPTH = tbl_depth(FOLD_W);

  logic [BITS-1:0] rom [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    localparam logic [MAX_W-1:0] ENTRY = fold_tbl_entry(g, BITS, MAX_W'(MODULUS));
    assign rom[g] = ENTRY[BITS-1:0];
  end

`ifdef FOLD_MOD_TABLE_BRAM_EN
  // Registered read port; data for an address appears the following cycle.
  always_ff @(posedge i_clk) begin
    data <= rom[addr];
  end
`else
  // Combinational read port.
  always_comb begin
    data = rom[addr];
  end
`endif

endmodule

// File: rtl/fold_mod_reduce.sv
// Modular reduction of a 2*BITS-bit product to BITS bits (mod MODULUS).
// Horner fold of FOLD_W product bits per step through a lookup table,
// followed by two conditional subtractions. One transaction in flight.
// Optional macro FOLD_MOD_TABLE_BRAM_EN: registered table read, each fold
// step then takes an address phase and an accumulate phase.
module fold_mod_reduce
  import fold_mod_pkg::*;
#(
  parameter int               BITS    = 384,
  parameter logic [BITS-1:0]  MODULUS = ~(BITS'(316)),
  parameter int               FOLD_W  = 8
)(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_val,
  output logic                o_rdy,
  input  logic [2*BITS-1:0]   i_dat,
  output logic                o_val,
  input  logic                i_rdy,
  output logic [BITS-1:0]     o_dat
);

  localparam int              NUM_STEP = num_step(BITS, FOLD_W);
  localparam int              CNT_W    = $clog2(NUM_STEP + 1);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(NUM_STEP - 1);
  localparam logic [BITS:0]   MOD_X    = {1'b0, MODULUS};

  if (MODULUS[BITS-1] != 1'b1) begin : g_bad_modulus
    $error("fold_mod_reduce: MODULUS must have its top bit set");
  end
  if (BITS % FOLD_W != 0) begin : g_bad_fold_w
    $error("fold_mod_reduce: BITS must be a multiple of FOLD_W");
  end

  // One conditional subtraction; the accumulator is below 3*MODULUS after
  // folding because the modulus top bit is set, so two passes fully reduce.
  function automatic logic [BITS:0] cond_sub(input logic [BITS:0] a);
    return (a >= MOD_X) ? (a - MOD_X) : a;
  endfunction

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [BITS:0]       acc;
  logic [BITS-1:0]     rem;
  logic [BITS+FOLD_W:0] sum;
  logic [FOLD_W:0]     hi;
  logic [BITS-1:0]     lo;
  logic [BITS-1:0]     tbl;
  logic [BITS:0]       fold_nxt;
  logic [BITS:0]       acc_sub;
  logic                step_en;

  assign sum      = {acc, rem[BITS-1 -: FOLD_W]};
  assign hi       = sum[BITS+FOLD_W:BITS];
  assign lo       = sum[BITS-1:0];
  assign fold_nxt = {1'b0, lo} + {1'b0, tbl};
  assign acc_sub  = cond_sub(acc);
  assign o_rdy    = (state == IDLE);
  assign o_val    = (state == DONE);

  fold_mod_table #(
    .BITS    (BITS),
    .MODULUS (MODULUS),
    .FOLD_W  (FOLD_W)
  ) u_tbl (
`ifdef FOLD_MOD_TABLE_BRAM_EN
    .i_clk   (i_clk),
`endif
    .addr    (hi),
    .data    (tbl)
  );

`ifdef FOLD_MOD_TABLE_BRAM_EN
  logic phase;

  // Phase bit: 0 = table address presented, 1 = table data valid, accumulate.
  always_ff @(posedge i_clk) begin
    if (i_rst) phase <= 1'b0;
    else       phase <= (state == ITER) ? ~phase : 1'b0;
  end

  assign step_en = (state == ITER) && phase;
`else
  assign step_en = (state == ITER);
`endif

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_val) state_nxt = ITER;
      ITER:    if (step_en && (cnt == LAST)) state_nxt = SUB1;
      SUB1:    state_nxt = SUB2;
      SUB2:    state_nxt = DONE;
      DONE:    if (i_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers: state, step counter and the held result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= '0;
      o_dat <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && i_val)
        cnt <= '0;
      else if (step_en && (cnt != LAST))
        cnt <= cnt + CNT_W'(1);
      if (state == SUB2)
        o_dat <= acc_sub[BITS-1:0];
    end
  end

  // Datapath: load halves of the product, fold, then reduce.
  always_ff @(posedge i_clk) begin
    case (state)
      IDLE: if (i_val) begin
        acc <= {1'b0, i_dat[2*BITS-1:BITS]};
        rem <= i_dat[BITS-1:0];
      end
      ITER: if (step_en) begin
        acc <= fold_nxt;
        rem <= rem << FOLD_W;
      end
      SUB1, SUB2: acc <= acc_sub;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fold_mod_reduce.sv
// Self-checking bench for fold_mod_reduce: a small instance (BITS=16,
// MODULUS=65521, FOLD_W=4) for directed latency/handshake/reset cases and
// a default 384-bit instance for randomized products. Expected results come
// from the % operator on the full product.
module tb_fold_mod_reduce;
  import fold_mod_pkg::*;

`ifdef FOLD_MOD_TABLE_BRAM_EN
  localparam int S_LAT    = 2*4 + 3;
  localparam int S_PERIOD = 2*4 + 4;
`else
  localparam int S_LAT    = 4 + 3;
  localparam int S_PERIOD = 4 + 4;
`endif

  localparam logic [767:0] MOD_BIG = (768'd1 << 384) - 768'd317;
  localparam logic [385:0] B_BOUND = (386'd1 << 385) - 386'd317;
  localparam logic [17:0]  S_BOUND = 18'd131057;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         s_ival, s_ordy, s_oval, s_irdy;
  logic [31:0]  s_dat;
  logic [15:0]  s_odat;
  logic         b_ival, b_ordy, b_oval, b_irdy;
  logic [767:0] b_dat;
  logic [383:0] b_odat;

  fold_mod_reduce #(.BITS(16), .MODULUS(16'd65521), .FOLD_W(4)) u_small (
    .i_clk(clk), .i_rst(rst), .i_val(s_ival), .o_rdy(s_ordy), .i_dat(s_dat),
    .o_val(s_oval), .i_rdy(s_irdy), .o_dat(s_odat)
  );

  fold_mod_reduce u_big (
    .i_clk(clk), .i_rst(rst), .i_val(b_ival), .o_rdy(b_ordy), .i_dat(b_dat),
    .o_val(b_oval), .i_rdy(b_irdy), .o_dat(b_odat)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int s_acc_n = 0, s_out_n = 0, b_acc_n = 0, b_out_n = 0;
  int s_viol  = 0, b_viol  = 0;
  logic [383:0] sq[$];
  logic [383:0] bq[$];

  task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [383:0] ref_small(input logic [31:0] d);
    return 384'(d % 32'd65521);
  endfunction

  function automatic logic [383:0] ref_big(input logic [767:0] d);
    logic [767:0] r;
    r = d % MOD_BIG;
    return r[383:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboards: queue the model result on accept, compare on output.
  always @(negedge clk) begin
    if (rst) begin
      sq.delete();
      bq.delete();
    end else begin
      if (s_ival && s_ordy) begin sq.push_back(ref_small(s_dat)); s_acc_n++; end
      if (s_oval && s_irdy) begin
        if (sq.size() == 0) check("s_spurious_out", 384'(s_odat), 384'd0 - 1);
        else check("s_result", 384'(s_odat), sq.pop_front());
        s_out_n++;
      end
      if (b_ival && b_ordy) begin bq.push_back(ref_big(b_dat)); b_acc_n++; end
      if (b_oval && b_irdy) begin
        if (bq.size() == 0) check("b_spurious_out", b_odat, 384'd0 - 1);
        else check("b_result", b_odat, bq.pop_front());
        b_out_n++;
      end
      if (u_small.acc >= S_BOUND) s_viol++;
      if (u_big.acc >= B_BOUND) b_viol++;
    end
  end

  task automatic s_send(input logic [31:0] d, output int t0);
    int n;
    n = 0;
    @(posedge clk); #1;
    s_dat = d; s_ival = 1'b1;
    @(negedge clk);
    while (!s_ordy && n < 300) begin @(negedge clk); n++; end
    if (!s_ordy) check("s_accept_timeout", 384'(s_ordy), 384'd1);
    t0 = cyc;
    @(posedge clk); #1;
    s_ival = 1'b0;
  endtask

  task automatic s_wait_val(output int tv, output logic [15:0] got);
    int n;
    n = 0;
    @(negedge clk);
    while (!s_oval && n < 300) begin @(negedge clk); n++; end
    if (!s_oval) check("s_valid_timeout", 384'(s_oval), 384'd1);
    tv = cyc;
    got = s_odat;
  endtask

  task automatic b_txn(input logic [767:0] d);
    int n, start;
    n = 0;
    start = b_out_n;
    @(posedge clk); #1;
    b_dat = d; b_ival = 1'b1;
    @(negedge clk);
    while (!b_ordy && n < 300) begin @(negedge clk); n++; end
    if (!b_ordy) check("b_accept_timeout", 384'(b_ordy), 384'd1);
    @(posedge clk); #1;
    b_ival = 1'b0;
    n = 0;
    while (b_out_n == start && n < 300) begin @(negedge clk); n++; end
    if (b_out_n == start) check("b_out_timeout", 384'(b_out_n - start), 384'd1);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t0, tv, bad, a0, o0, n_acc, last, guard, n;
    logic [15:0] got, d0;
    logic [767:0] sp[5];
    logic [767:0] bd;

    rst = 1'b1;
    s_ival = 1'b0; s_dat = '0; s_irdy = 1'b1;
    b_ival = 1'b0; b_dat = '0; b_irdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_s_oval", 384'(s_oval), 384'd0);
    check("rst_s_odat", 384'(s_odat), 384'd0);
    check("rst_s_ordy", 384'(s_ordy), 384'd1);
    check("rst_b_oval", 384'(b_oval), 384'd0);
    check("rst_b_odat", b_odat, 384'd0);
    check("rst_b_ordy", 384'(b_ordy), 384'd1);

    // Directed values and first-transaction latency
    s_send(32'd0, t0); s_wait_val(tv, got);
    check("lat_zero", 384'(tv - t0), 384'(S_LAT));
    check("res_zero", 384'(got), 384'd0);
    s_send(32'hFFE00100, t0); s_wait_val(tv, got);
    check("res_sq_minus1", 384'(got), 384'd1);
    check("lat_sq_minus1", 384'(tv - t0), 384'(S_LAT));
    s_send(32'hFFFFFFFF, t0); s_wait_val(tv, got);
    check("res_all_ones", 384'(got), 384'd224);
    s_send(32'd65521, t0); s_wait_val(tv, got);
    check("res_modulus", 384'(got), 384'd0);

    // Backpressure in DONE
    @(posedge clk); #1 s_irdy = 1'b0;
    s_send(32'h12345678, t0); s_wait_val(tv, got);
    check("bp_value", 384'(got), ref_small(32'h12345678));
    d0 = got; bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!s_oval || s_odat !== d0 || s_ordy) bad++;
    end
    check("bp_hold", 384'(bad), 384'd0);
    @(posedge clk); #1 s_irdy = 1'b1;
    @(negedge clk);
    check("bp_release_val", 384'(s_oval), 384'd1);
    @(negedge clk);
    check("bp_release_rdy", 384'(s_ordy), 384'd1);
    check("bp_release_oval", 384'(s_oval), 384'd0);

    // Reset in the middle of the fold
    s_send(32'hFFFFFFFF, t0); s_wait_val(tv, got);
    s_send(32'hDEADBEEF, t0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_state", 384'(u_small.state), 384'(IDLE));
    check("mid_rst_oval", 384'(s_oval), 384'd0);
    check("mid_rst_odat", 384'(s_odat), 384'd0);
    check("mid_rst_ordy", 384'(s_ordy), 384'd1);
    s_send(32'hFFE00100, t0); s_wait_val(tv, got);
    check("post_rst_res", 384'(got), 384'd1);

    // Continuous i_val: fixed accept spacing, no drop or duplicate
    a0 = s_acc_n; o0 = s_out_n;
    n_acc = 0; last = -1; guard = 0;
    @(posedge clk); #1;
    s_dat = $urandom; s_ival = 1'b1;
    while (n_acc < 6 && guard < 200) begin
      @(negedge clk); guard++;
      if (s_ordy) begin
        if (last >= 0) check("cont_spacing", 384'(cyc - last), 384'(S_PERIOD));
        last = cyc; n_acc++;
        @(posedge clk); #1 s_dat = $urandom;
      end
    end
    s_ival = 1'b0;
    n = 0;
    while (s_out_n - o0 < 6 && n < 100) begin @(negedge clk); n++; end
    check("cont_accepts", 384'(s_acc_n - a0), 384'd6);
    check("cont_outputs", 384'(s_out_n - o0), 384'd6);

    // Small-config random with random downstream stalls
    for (int i = 0; i < 150; i++) begin
      int st;
      st = s_out_n;
      case (i)
        0: bd[31:0] = 32'd65521 * 32'd65521 - 32'd1;
        1: bd[31:0] = 32'd65520;
        default: bd[31:0] = $urandom;
      endcase
      s_send(bd[31:0], t0);
      n = 0;
      while (s_out_n == st && n < 300) begin
        @(posedge clk); #1 s_irdy = ($urandom_range(0, 3) != 0);
        @(negedge clk); n++;
      end
      if (s_out_n == st) check("s_rand_timeout", 384'(s_out_n - st), 384'd1);
      @(posedge clk); #1 s_irdy = 1'b1;
    end

    // Default configuration: special values then random products
    sp[0] = '1;
    sp[1] = MOD_BIG * MOD_BIG - 768'd1;
    sp[2] = '0;
    sp[3] = MOD_BIG;
    sp[4] = MOD_BIG - 768'd1;
    for (int i = 0; i < 5; i++) b_txn(sp[i]);
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 24; k++) bd[k*32 +: 32] = $urandom;
      if (i % 3 == 1) bd[767:384] = bd[767:384] | {384{1'b1}} << $urandom_range(0, 64);
      b_txn(bd);
    end

    check("s_acc_bound", 384'(s_viol), 384'd0);
    check("b_acc_bound", 384'(b_viol), 384'd0);
    check("s_queue_empty", 384'(sq.size()), 384'd0);
    check("b_queue_empty", 384'(bq.size()), 384'd0);
    check("b_count", 384'(b_out_n), 384'd305);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
